// File: rtl/core_mem_arbiter_if.sv
// Memory-side request/response bus of the Core memory arbiter.
//   m_valid  request valid (arbiter -> memory)
//   m_ready  memory accepts the request in a cycle where m_valid is high
//   m_addr   request word address
//   m_we     request byte enables, 0 = read
//   m_wdata  request write data
//   m_rvalid one-cycle response strobe (read data or write acknowledge)
//   m_rdata  response data, meaningful only while m_rvalid is high
// The master modport is the arbiter; the slave modport is the bus wrapper / memory.
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_we;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_valid, m_addr, m_we, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_addr, m_we, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one memory master port between the Core's instruction-fetch (I) and
// data (D) requesters. Each access runs grant -> request/accept -> response ->
// done, with D winning when both are pending at the arbitration point (IDLE).
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   i_req/i_addr       fetch request (level, held until its done cycle)
//   i_rdata            fetch data, updated in the I done cycle and held
//   sync_i             I access outstanding (Core stalls while high)
//   d_req/d_we/d_addr/d_wdata  data request, d_we = 0 means read
//   d_rdata            load data, updated in the D done cycle and held
//   sync_d             D access outstanding
//   mem                memory-side bus (master modport)
//   err                sticky timeout flag, cleared only by reset
module core_mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [DATA_W-1:0]  i_rdata,
    output logic               sync_i,
    input  logic               d_req,
    input  logic [3:0]         d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               sync_d,
    core_mem_arbiter_if.master mem,
    output logic               err
);
    // Counter is at least 8 bits wide so small TIMEOUT values still share one layout.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The counter reads k in the (k+1)-th REQ/WAIT cycle, so this value marks
    // the last cycle allowed before the access is forced to DONE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_REQ,
        I_WAIT,
        D_REQ,
        D_WAIT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_i_reg;
    logic             done_d_reg;

    logic serving_d;
    logic timed_out;
    logic is_read;

    assign serving_d = (state_reg == D_REQ) || (state_reg == D_WAIT);
    assign timed_out = (cnt_reg >= CNT_LAST);
    assign is_read   = (mem.m_we == 4'b0000);

    // Stall drops in the done cycle so the Core advances exactly once per access.
    assign sync_i = i_req & ~done_i_reg;
    assign sync_d = d_req & ~done_d_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            done_i_reg  <= 1'b0;
            done_d_reg  <= 1'b0;
            mem.m_valid <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_we    <= '0;
            mem.m_wdata <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            err         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    // Request fields are captured here and never re-sampled.
                    if (d_req) begin
                        state_reg   <= D_REQ;
                        mem.m_valid <= 1'b1;
                        mem.m_addr  <= d_addr;
                        mem.m_we    <= d_we;
                        mem.m_wdata <= d_wdata;
                    end else if (i_req) begin
                        state_reg   <= I_REQ;
                        mem.m_valid <= 1'b1;
                        mem.m_addr  <= i_addr;
                        mem.m_we    <= 4'b0000;
                        mem.m_wdata <= '0;
                    end
                end

                I_REQ, D_REQ: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (mem.m_ready) begin
                        mem.m_valid <= 1'b0;
                        state_reg   <= serving_d ? D_WAIT : I_WAIT;
                    end else if (timed_out) begin
                        mem.m_valid <= 1'b0;
                        state_reg   <= DONE;
                        err         <= 1'b1;
                        if (serving_d) begin
                            done_d_reg <= 1'b1;
                            if (is_read) begin
                                d_rdata <= '0;
                            end
                        end else begin
                            done_i_reg <= 1'b1;
                            i_rdata    <= '0;
                        end
                    end
                end

                I_WAIT, D_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A real response wins over a timeout landing in the same cycle.
                    if (mem.m_rvalid || timed_out) begin
                        state_reg <= DONE;
                        if (!mem.m_rvalid) begin
                            err <= 1'b1;
                        end
                        if (serving_d) begin
                            done_d_reg <= 1'b1;
                            if (is_read) begin
                                d_rdata <= mem.m_rvalid ? mem.m_rdata : '0;
                            end
                        end else begin
                            done_i_reg <= 1'b1;
                            i_rdata    <= mem.m_rvalid ? mem.m_rdata : '0;
                        end
                    end
                end

                DONE: begin
                    state_reg  <= IDLE;
                    done_i_reg <= 1'b0;
                    done_d_reg <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rdata;
    logic              sync_i;
    logic              d_req = 1'b0;
    logic [3:0]        d_we = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              sync_d;
    logic              err;

    core_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    core_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .sync_i  (sync_i),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .sync_d  (sync_d),
        .mem     (mif),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        we;
        logic [DATA_W-1:0] wdata;
    } req_t;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected memory-side requests in order, expected rdata per requester.
    req_t              acc_q[$];
    logic [DATA_W-1:0] i_exp_q[$];
    logic [DATA_W-1:0] d_exp_q[$];

    // Reference memory (bench model) and the memory behind the slave port.
    logic [DATA_W-1:0] ref_mem[int];
    logic [DATA_W-1:0] slv_mem[int];
    logic [DATA_W-1:0] d_last = '0;

    // Slave knobs: ready_delay < 0 random, else cycles of m_valid before m_ready.
    // resp_lat < 0 random 1..3, 0 never respond, else fixed cycles after accept.
    int ready_delay = 0;
    int resp_lat    = 1;
    bit spur_en     = 1'b0;
    int inject_req  = 0;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], 8'h5A, 2'b01, a};
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    function automatic void ref_write(input logic [ADDR_W-1:0] a, input logic [3:0] we,
                                      input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] cur;
        cur = ref_read(a);
        for (int b = 0; b < 4; b++) begin
            if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
        end
        ref_mem[int'(a)] = cur;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {2'($urandom_range(0, 3)), 8'h00, 4'($urandom_range(0, 7))};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory slave: observes each cycle at negedge, drives the next cycle after posedge.
    initial begin
        bit                acc;
        bit                resp_pend;
        bit                do_inject;
        int                resp_cnt;
        int                vcnt;
        int                inject_seen;
        int                a;
        logic [DATA_W-1:0] resp_data;
        logic [DATA_W-1:0] cur;
        resp_pend   = 1'b0;
        do_inject   = 1'b0;
        resp_cnt    = 0;
        vcnt        = 0;
        inject_seen = 0;
        resp_data   = '0;
        mif.m_ready  = 1'b0;
        mif.m_rvalid = 1'b0;
        mif.m_rdata  = '0;
        forever begin
            @(negedge clk);
            acc = mif.m_valid && mif.m_ready;
            if (!rst_n) begin
                resp_pend = 1'b0;
                vcnt      = 0;
            end else if (acc) begin
                a = int'(mif.m_addr);
                cur = slv_mem.exists(a) ? slv_mem[a] : init_word(mif.m_addr);
                if (mif.m_we == 4'b0000) begin
                    resp_data = cur;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (mif.m_we[b]) cur[8*b +: 8] = mif.m_wdata[8*b +: 8];
                    end
                    slv_mem[a] = cur;
                    resp_data  = $urandom;
                end
                if (resp_lat != 0) begin
                    resp_pend = 1'b1;
                    resp_cnt  = (resp_lat < 0) ? int'($urandom_range(1, 3)) : resp_lat;
                end
            end
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                do_inject   = 1'b1;
            end
            vcnt = (rst_n && mif.m_valid && !acc) ? vcnt + 1 : 0;

            @(posedge clk);
            #1;
            mif.m_rvalid = 1'b0;
            mif.m_rdata  = $urandom;
            if (do_inject) begin
                mif.m_rvalid = 1'b1;
                mif.m_rdata  = 32'hBAD0_0001;
                do_inject    = 1'b0;
            end else if (resp_pend) begin
                resp_cnt--;
                if (resp_cnt <= 0) begin
                    mif.m_rvalid = 1'b1;
                    mif.m_rdata  = resp_data;
                    resp_pend    = 1'b0;
                end
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                mif.m_rvalid = 1'b1;
            end
            mif.m_ready = (ready_delay < 0) ? ($urandom_range(0, 2) != 0) : (vcnt >= ready_delay);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT accepts a request or completes one.
    initial begin
        req_t prev;
        req_t e;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(mif.m_valid), 64'd1);
                check("hold_fields", 64'({mif.m_addr, mif.m_we, mif.m_wdata}), 64'(prev));
            end
            if (mif.m_valid && mif.m_ready) begin
                if (acc_q.size() == 0) begin
                    check("accept_expected", 64'(acc_q.size()), 64'd1);
                end else begin
                    e = acc_q.pop_front();
                    check("accept_addr", 64'(mif.m_addr), 64'(e.addr));
                    check("accept_we", 64'(mif.m_we), 64'(e.we));
                    if (e.we != 4'b0000) check("accept_wdata", 64'(mif.m_wdata), 64'(e.wdata));
                end
            end
            prev_stall = mif.m_valid && !mif.m_ready;
            prev       = {mif.m_addr, mif.m_we, mif.m_wdata};
            if (i_req && !sync_i) begin
                if (i_exp_q.size() == 0) check("i_done_expected", 64'(i_exp_q.size()), 64'd1);
                else check("i_rdata", 64'(i_rdata), 64'(i_exp_q.pop_front()));
            end
            if (d_req && !sync_d) begin
                if (d_exp_q.size() == 0) check("d_done_expected", 64'(d_exp_q.size()), 64'd1);
                else check("d_rdata", 64'(d_rdata), 64'(d_exp_q.pop_front()));
            end
        end
    end

    // One access (I, D or both raised together from an idle arbiter). Expected
    // results go to the scoreboard in service order: D before I.
    task automatic run_txn(input bit use_i, input logic [ADDR_W-1:0] ia,
                           input bit use_d, input logic [3:0] we,
                           input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd,
                           input bit exp_to, input bit scramble,
                           output int ic, output int dc, output int mc);
        req_t r;
        bit   i_pend, d_pend, i_seen, d_seen;
        int   budget;
        logic [DATA_W-1:0] iv;
        if (use_d) begin
            r.addr = da; r.we = we; r.wdata = wd;
            acc_q.push_back(r);
            if (we == 4'b0000) d_last = exp_to ? '0 : ref_read(da);
            else ref_write(da, we, wd);
            d_exp_q.push_back(d_last);
        end
        if (use_i) begin
            r.addr = ia; r.we = 4'b0000; r.wdata = '0;
            acc_q.push_back(r);
            iv = exp_to ? '0 : ref_read(ia);
            i_exp_q.push_back(iv);
        end
        @(posedge clk);
        #1;
        i_req = use_i; i_addr = ia;
        d_req = use_d; d_we = we; d_addr = da; d_wdata = wd;
        i_pend = use_i; d_pend = use_d;
        ic = 0; dc = 0; mc = 0; budget = 0;
        while ((i_pend || d_pend) && budget < 1000) begin
            @(negedge clk);
            budget++;
            i_seen = 1'b0;
            d_seen = 1'b0;
            if (mif.m_valid) mc++;
            if (i_pend) begin
                if (sync_i) ic++; else i_seen = 1'b1;
            end
            if (d_pend) begin
                if (sync_d) dc++; else d_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            // The first requester was granted at the edge just passed; later
            // changes to its fields must not reach the memory port.
            if (scramble && budget == 1) begin
                if (use_d) begin
                    d_addr = ADDR_W'($urandom); d_we = 4'($urandom); d_wdata = $urandom;
                end else begin
                    i_addr = ADDR_W'($urandom);
                end
            end
            if (i_seen) begin i_req = 1'b0; i_pend = 1'b0; end
            if (d_seen) begin d_req = 1'b0; d_pend = 1'b0; end
        end
        check("txn_complete", 64'({i_pend, d_pend}), 64'd0);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ic, dc, mc, kind, budget;
        bit   found;
        logic [3:0] we;
        req_t r;

        ref_mem[16]    = 32'h00A0_0093; slv_mem[16]    = 32'h00A0_0093;
        ref_mem[32'h300] = 32'h1234_5678; slv_mem[32'h300] = 32'h1234_5678;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(mif.m_valid), 64'd0);
        check("rst_m_fields", 64'({mif.m_addr, mif.m_we, mif.m_wdata}), 64'd0);
        check("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
        check("rst_err_sync", 64'({err, sync_i, sync_d}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single I read with ready/response at first opportunity.
        ready_delay = 0; resp_lat = 1; spur_en = 1'b0;
        run_txn(1'b1, 14'h010, 1'b0, 4'b0, '0, '0, 1'b0, 1'b0, ic, dc, mc);
        check("t1_sync_i_cycles", 64'(ic), 64'd3);
        check("t1_valid_cycles", 64'(mc), 64'd1);

        // Simultaneous requests: D first, I waits through D's done plus one IDLE.
        run_txn(1'b1, 14'h014, 1'b1, 4'b0000, 14'h300, '0, 1'b0, 1'b0, ic, dc, mc);
        check("t3_sync_d_cycles", 64'(dc), 64'd3);
        check("t3_sync_i_cycles", 64'(ic), 64'(dc + 4));

        // D partial write leaves d_rdata alone; read back shows the byte merge.
        run_txn(1'b0, '0, 1'b1, 4'b0011, 14'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, ic, dc, mc);
        check("t2_sync_d_cycles", 64'(dc), 64'd3);
        run_txn(1'b0, '0, 1'b1, 4'b0000, 14'h200, '0, 1'b0, 1'b0, ic, dc, mc);

        // Backpressure: five cycles of m_ready low, then one accept.
        ready_delay = 5;
        run_txn(1'b1, 14'h123, 1'b0, 4'b0, '0, '0, 1'b0, 1'b1, ic, dc, mc);
        check("t4_valid_cycles", 64'(mc), 64'd6);
        check("t4_sync_i_cycles", 64'(ic), 64'd8);

        // Randomized traffic with random handshake timing and stray m_rvalid pulses.
        ready_delay = -1; resp_lat = -1; spur_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 2));
            we   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            run_txn(kind != 1, rand_addr(), kind != 0, we, rand_addr(), $urandom,
                    1'b0, 1'b1, ic, dc, mc);
        end

        // Timeout: no response ever; completes after TIMEOUT cycles in REQ/WAIT.
        ready_delay = 0; resp_lat = 0; spur_en = 1'b0;
        check("t5_err_before", 64'(err), 64'd0);
        run_txn(1'b1, 14'h055, 1'b0, 4'b0, '0, '0, 1'b1, 1'b0, ic, dc, mc);
        check("t5_sync_i_cycles", 64'(ic), 64'(TIMEOUT + 1));
        check("t5_err_set", 64'(err), 64'd1);
        resp_lat = 1;
        run_txn(1'b1, 14'h010, 1'b0, 4'b0, '0, '0, 1'b0, 1'b0, ic, dc, mc);
        check("t5_err_sticky", 64'(err), 64'd1);

        // Reset while in I_WAIT, then a late m_rvalid which must be ignored.
        resp_lat = 0;
        r.addr = 14'h077; r.we = 4'b0000; r.wdata = '0;
        acc_q.push_back(r);
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 14'h077;
        found = 1'b0; budget = 0;
        while (!found && budget < 20) begin
            @(negedge clk);
            budget++;
            found = mif.m_valid && mif.m_ready;
        end
        check("t6_accept_seen", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; i_req = 1'b0; inject_req++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_i_rdata", 64'(i_rdata), 64'd0);
        check("t6_idle", 64'({mif.m_valid, sync_i, err}), 64'd0);

        // Normal service after the reset.
        resp_lat = 1;
        run_txn(1'b1, 14'h010, 1'b0, 4'b0, '0, '0, 1'b0, 1'b0, ic, dc, mc);
        check("t6_recover_cycles", 64'(ic), 64'd3);

        repeat (2) @(negedge clk);
        check("queues_drained", 64'(acc_q.size() + i_exp_q.size() + d_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
